// File: rtl/collision_arbiter_frame_if.sv
// collision_arbiter_frame_if: raster sample inputs and game-state outputs of the frame collision arbiter
interface collision_arbiter_frame_if #(
    parameter int N_OBJ   = 15,
    parameter int SCORE_W = 16,
    parameter int LIVES_W = 2
);
    logic               pix_valid;
    logic [9:0]         px;
    logic [9:0]         py;
    logic [N_OBJ-1:0]   pixels;
    logic               frame_end;
    logic [N_OBJ-1:0]   reset_obj;
    logic [SCORE_W-1:0] score;
    logic [LIVES_W-1:0] lives;
    logic               invuln;
    logic               game_over;

    modport master (
        output pix_valid, px, py, pixels, frame_end,
        input  reset_obj, score, lives, invuln, game_over
    );

    modport slave (
        input  pix_valid, px, py, pixels, frame_end,
        output reset_obj, score, lives, invuln, game_over
    );
endinterface

// File: rtl/collision_arbiter_frame.sv
// collision_arbiter_frame: accumulates per-frame object hits, applies score/lives/respawns at frame_end.
// Define BONUS_LIFE_EN to award an extra life each time the score crosses a multiple of BONUS_SCORE.
module collision_arbiter_frame #(
    parameter int N_BULLETS     = 4,
    parameter int N_ROCKS       = 10,
    parameter int SCORE_W       = 16,
    parameter int LIVES_W       = 2,
    parameter int START_LIVES   = 3,
    parameter int ROCK_POINTS   = 1,
    parameter int H_LIMIT       = 660,
    parameter int V_LIMIT       = 500,
    parameter int INVULN_FRAMES = 120,
    parameter int BONUS_SCORE   = 1000
) (
    input logic clk_60hz,
    input logic reset_game,
    collision_arbiter_frame_if.slave bus
);
    localparam int N_OBJ = 1 + N_BULLETS + N_ROCKS;
    localparam int CW    = $clog2(INVULN_FRAMES + 1);
    localparam int PCW   = $clog2(N_ROCKS + 1);

    typedef enum logic [1:0] {PLAY, INVULN, OVER} state_t;

    state_t               state;
    logic [N_OBJ-1:0]     border_acc, kill_acc, border_all, kill_all;
    logic [N_ROCKS-1:0]   rock_acc, rock_all, rocks;
    logic [N_BULLETS-1:0] bullets;
    logic                 ship_hit, hit_all, acc_en, in_border, br, sr;
    logic [CW-1:0]        cnt;
    logic [PCW-1:0]       pc;
    logic [SCORE_W:0]     sum;
    logic [SCORE_W-1:0]   score_n;
    logic [LIVES_W-1:0]   lives_b;

    assign bullets       = bus.pixels[N_BULLETS:1];
    assign rocks         = bus.pixels[N_OBJ-1:N_BULLETS+1];
    assign acc_en        = bus.pix_valid && state != OVER;
    assign in_border     = bus.px > 10'(H_LIMIT) || bus.py > 10'(V_LIMIT);
    assign br            = |bullets && |rocks;
    assign sr            = bus.pixels[0] && |rocks && state == PLAY;
    assign bus.invuln    = state == INVULN;
    assign bus.game_over = state == OVER;

    // *_all fold the current sample into the accumulators so a frame_end sample counts
    always_comb begin
        border_all = border_acc | (acc_en && in_border ? bus.pixels : '0);
        kill_all   = kill_acc | (acc_en && !in_border && br ? {rocks, bullets, 1'b0} :
                                 acc_en && !in_border && sr ? {rocks, {N_BULLETS{1'b0}}, 1'b1} : '0);
        rock_all   = rock_acc | (acc_en && !in_border && br ? rocks : '0);
        hit_all    = ship_hit || (acc_en && !in_border && !br && sr);
        pc = '0;
        for (int i = 0; i < N_ROCKS; i++) pc = pc + PCW'(rock_all[i]);
        sum     = {1'b0, bus.score} + (SCORE_W+1)'(pc * ROCK_POINTS);
        score_n = sum[SCORE_W] ? '1 : sum[SCORE_W-1:0];
`ifdef BONUS_LIFE_EN
        lives_b = (32'(score_n) / BONUS_SCORE > 32'(bus.score) / BONUS_SCORE) && bus.lives != '1 ?
                  bus.lives + 1'b1 : bus.lives;
`else
        lives_b = bus.lives;
`endif
    end

    always_ff @(posedge clk_60hz) begin
        if (reset_game) begin
            state         <= PLAY;
            bus.score     <= '0;
            bus.lives     <= LIVES_W'(START_LIVES);
            bus.reset_obj <= '1;
            cnt           <= '0;
            border_acc    <= '0;
            kill_acc      <= '0;
            rock_acc      <= '0;
            ship_hit      <= 1'b0;
        end else begin
            bus.reset_obj <= '0;
            if (bus.frame_end && state != OVER) begin
                bus.reset_obj <= border_all | kill_all;
                bus.score     <= score_n;
                border_acc    <= '0;
                kill_acc      <= '0;
                rock_acc      <= '0;
                ship_hit      <= 1'b0;
                if (hit_all) begin
                    if (lives_b <= LIVES_W'(1)) begin
                        bus.lives <= '0;
                        state     <= OVER;
                    end else begin
                        bus.lives <= lives_b - 1'b1;
                        state     <= INVULN;
                        cnt       <= CW'(INVULN_FRAMES);
                    end
                end else begin
                    bus.lives <= lives_b;
                    if (state == INVULN) begin
                        cnt <= cnt - 1'b1;
                        if (cnt == CW'(1)) state <= PLAY;
                    end
                end
            end else begin
                border_acc <= border_all;
                kill_acc   <= kill_all;
                rock_acc   <= rock_all;
                ship_hit   <= hit_all;
            end
        end
    end
endmodule
